// File: rtl/pmod_ssd_scan_if.sv
// pmod_ssd_scan_if
// Groups the data-side and pin-side signals of the multiplexed seven-segment
// scanner into one bundle. The clock and reset stay as plain ports on the
// scanner.
//
// Signals (names are from the scanner's point of view):
//   i_data        [4*NUM_DIGITS] hex nibbles, nibble k = digit k
//   i_dp          [NUM_DIGITS]   decimal point per digit, sampled live
//   i_load        1              one-cycle request to capture i_data
//   i_blank_zeros 1              leading-zero suppression enable, live
//   i_brightness  [PWM_WIDTH]    duty control, 0 = dark, all ones = full on
//   o_seg         7              segments {g,f,e,d,c,b,a}, active high
//   o_dp          1              decimal point of the active digit
//   o_digit_en    [NUM_DIGITS]   one-hot active digit enable
//   o_seg_sel     1              LSB of the active digit index
//   o_pending     1              loaded data not yet committed to display
//   o_frame_done  1              one-cycle pulse when the scan wraps
//
// Modports: master = data source / pin observer, slave = the scanner.
interface pmod_ssd_scan_if #(
    parameter int NUM_DIGITS = 2,
    parameter int PWM_WIDTH  = 4
);
    logic [4*NUM_DIGITS-1:0] i_data;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic                    i_load;
    logic                    i_blank_zeros;
    logic [PWM_WIDTH-1:0]    i_brightness;
    logic [6:0]              o_seg;
    logic                    o_dp;
    logic [NUM_DIGITS-1:0]   o_digit_en;
    logic                    o_seg_sel;
    logic                    o_pending;
    logic                    o_frame_done;

    modport master (
        output i_data, i_dp, i_load, i_blank_zeros, i_brightness,
        input  o_seg, o_dp, o_digit_en, o_seg_sel, o_pending, o_frame_done
    );

    modport slave (
        input  i_data, i_dp, i_load, i_blank_zeros, i_brightness,
        output o_seg, o_dp, o_digit_en, o_seg_sel, o_pending, o_frame_done
    );
endinterface

// File: rtl/pmod_ssd_scan.sv
// pmod_ssd_scan
// Multiplexed seven-segment display driver. Scans NUM_DIGITS hex digits with
// a one-hot digit enable, each digit slot lasting 2^CLK_DIV_WIDTH clocks.
// Data loads are double buffered so a frame never mixes old and new digits,
// leading zeros can be blanked, each digit has its own decimal point, the
// whole display is PWM dimmed and a strobe marks each completed frame.
//
// Ports:
//   i_clock_125MHz  system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   ssd             pmod_ssd_scan_if.slave bundle (data in, pins out)
//
// All pin outputs are registered and lag the scan state by one clock.
module pmod_ssd_scan #(
    parameter int NUM_DIGITS    = 2,
    parameter int CLK_DIV_WIDTH = 15,
    parameter int PWM_WIDTH     = 4
) (
    input  logic            i_clock_125MHz,
    input  logic            i_reset_n,
    pmod_ssd_scan_if.slave  ssd
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Scan state
    logic [CLK_DIV_WIDTH-1:0] cnt_r;
    logic [IDX_W-1:0]         idx_r;
    logic [DATA_W-1:0]        staging_r;
    logic [DATA_W-1:0]        display_r;
    logic                     pending_r;

    // Registered pin drivers
    logic [6:0]               seg_r;
    logic                     dp_r;
    logic [NUM_DIGITS-1:0]    digit_en_r;
    logic                     seg_sel_r;
    logic                     frame_done_r;

    // Combinational next values
    logic                     tick_s;
    logic                     wrap_s;
    logic [NUM_DIGITS-1:0]    zero_from_s;
    logic [3:0]               nib_s;
    logic                     dp_sel_s;
    logic                     zero_sel_s;
    logic                     blank_s;
    logic                     on_s;
    logic [6:0]               seg_nxt_s;
    logic                     dp_nxt_s;
    logic [NUM_DIGITS-1:0]    digit_en_nxt_s;

    assign tick_s = &cnt_r;
    assign wrap_s = tick_s && (idx_r == LAST_IDX);

    // Free-running prescaler; one full wrap is one digit slot.
    always_ff @(posedge i_clock_125MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r <= {CLK_DIV_WIDTH{1'b0}};
        end else begin
            cnt_r <= cnt_r + CLK_DIV_WIDTH'(1'b1);
        end
    end

    // Digit index advances once per slot and wraps after the last digit.
    always_ff @(posedge i_clock_125MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (tick_s) begin
            if (idx_r == LAST_IDX) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1'b1);
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Double buffer: loads land in staging and are committed only at the
    // frame boundary. A load on the boundary cycle itself bypasses staging
    // so the new value is never left waiting a whole extra frame.
    always_ff @(posedge i_clock_125MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            staging_r <= {DATA_W{1'b0}};
            display_r <= {DATA_W{1'b0}};
            pending_r <= 1'b0;
        end else if (wrap_s && ssd.i_load) begin
            staging_r <= ssd.i_data;
            display_r <= ssd.i_data;
            pending_r <= 1'b0;
        end else if (wrap_s) begin
            staging_r <= staging_r;
            display_r <= staging_r;
            pending_r <= 1'b0;
        end else if (ssd.i_load) begin
            staging_r <= ssd.i_data;
            display_r <= display_r;
            pending_r <= 1'b1;
        end else begin
            staging_r <= staging_r;
            display_r <= display_r;
            pending_r <= pending_r;
        end
    end

    // Pick the active digit, apply blanking and PWM gating.
    always_comb begin
        nib_s      = display_r[3:0];
        dp_sel_s   = ssd.i_dp[0];
        zero_sel_s = 1'b0;
        // zero_from_s[k]: nibbles k..NUM_DIGITS-1 are all zero. Shifting
        // right by 4*k drops the lower nibbles and fills with zeros.
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_from_s[k] = ~|(display_r >> (4 * k));
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib_s      = (idx_r == IDX_W'(k)) ? display_r[4*k +: 4] : nib_s;
            dp_sel_s   = (idx_r == IDX_W'(k)) ? ssd.i_dp[k]         : dp_sel_s;
            zero_sel_s = (idx_r == IDX_W'(k)) ? zero_from_s[k]      : zero_sel_s;
        end
        // Digit 0 always shows something, even a plain zero.
        blank_s = ssd.i_blank_zeros && (idx_r != {IDX_W{1'b0}}) && zero_sel_s;
        // All-ones brightness is forced on so full duty really is 100%.
        on_s = (&ssd.i_brightness) ||
               (cnt_r[CLK_DIV_WIDTH-1 -: PWM_WIDTH] < ssd.i_brightness);
        if (on_s) begin
            seg_nxt_s      = blank_s ? 7'h00 : hex_to_seg(nib_s);
            dp_nxt_s       = dp_sel_s;
            digit_en_nxt_s = NUM_DIGITS'(1'b1) << idx_r;
        end else begin
            seg_nxt_s      = 7'h00;
            dp_nxt_s       = 1'b0;
            digit_en_nxt_s = {NUM_DIGITS{1'b0}};
        end
    end

    // Register every pin so the connector sees glitch-free levels.
    always_ff @(posedge i_clock_125MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seg_r        <= 7'h00;
            dp_r         <= 1'b0;
            digit_en_r   <= {NUM_DIGITS{1'b0}};
            seg_sel_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            dp_r         <= dp_nxt_s;
            digit_en_r   <= digit_en_nxt_s;
            seg_sel_r    <= idx_r[0];
            frame_done_r <= wrap_s;
        end
    end

    assign ssd.o_seg        = seg_r;
    assign ssd.o_dp         = dp_r;
    assign ssd.o_digit_en   = digit_en_r;
    assign ssd.o_seg_sel    = seg_sel_r;
    assign ssd.o_pending    = pending_r;
    assign ssd.o_frame_done = frame_done_r;

endmodule
